// File: rtl/bridge_burst_reader.sv
// Block reader for the external-bus-to-Avalon bridge: fetches consecutive 16-bit words
// one transaction at a time into a fall-through FIFO drained by a valid/ready consumer.
module bridge_burst_reader #(
   parameter int ADDR_W     = 26,
   parameter int DATA_W     = 16,
   parameter int LEN_W      = 12,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     start_addr,
   input  logic [LEN_W-1:0]      word_count,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_W-1:0]     bridge_address,
   output logic [DATA_W/8-1:0]   bridge_byte_enable,
   output logic                  bridge_read,
   output logic                  bridge_write,
   output logic [DATA_W-1:0]     bridge_write_data,
   input  logic                  bridge_acknowledge,
   input  logic [DATA_W-1:0]     bridge_read_data,
   output logic [DATA_W-1:0]     out_data,
   output logic                  out_valid,
   input  logic                  out_ready
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_REQ   = 2'd2;
   localparam logic [1:0] S_GAP   = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  remaining_q, remaining_d;
   logic              abort_pending_q, abort_pending_d;
   logic              done_q, done_d;
   logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

   logic [PTR_W:0]    fifo_count;
   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              pop;
   logic              flush;
   logic              abort_seen;

   assign fifo_count = wr_ptr_q - rd_ptr_q;
   assign fifo_full  = (fifo_count == FULL_CNT);
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   // Only an acknowledge that answers our own request carries data.
   assign push       = (state_q == S_REQ) && bridge_acknowledge;
   assign pop        = !fifo_empty && out_ready;
   assign abort_seen = abort || abort_pending_q;

   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      remaining_d     = remaining_q;
      abort_pending_d = abort_pending_q;
      done_d          = 1'b0;
      flush           = 1'b0;
      case (state_q)
         S_IDLE: begin
            abort_pending_d = 1'b0;
            if (start) begin
               if (word_count == '0) begin
                  done_d = 1'b1;
               end else begin
                  addr_d      = start_addr & ~ADDR_W'(1);
                  remaining_d = word_count;
                  state_d     = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            if (abort_seen) begin
               state_d         = S_IDLE;
               abort_pending_d = 1'b0;
               flush           = 1'b1;
            end else if (!fifo_full) begin
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            abort_pending_d = abort_pending_q | abort;
            if (bridge_acknowledge) begin
               addr_d      = addr_q + ADDR_W'(2);
               remaining_d = remaining_q - LEN_W'(1);
               if (abort_seen) begin
                  state_d         = S_IDLE;
                  abort_pending_d = 1'b0;
                  flush           = 1'b1;
               end else if (remaining_q == LEN_W'(1)) begin
                  // Finishing here makes busy fall together with the done pulse.
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_GAP;
               end
            end
         end
         default: begin
            if (abort_seen) begin
               state_d         = S_IDLE;
               abort_pending_d = 1'b0;
               flush           = 1'b1;
            end else if (remaining_q == '0) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_ISSUE;
            end
         end
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q + (PTR_W + 1)'(push);
      rd_ptr_d = rd_ptr_q + (PTR_W + 1)'(pop);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= S_IDLE;
         addr_q          <= '0;
         remaining_q     <= '0;
         abort_pending_q <= 1'b0;
         done_q          <= 1'b0;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         remaining_q     <= remaining_d;
         abort_pending_q <= abort_pending_d;
         done_q          <= done_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[PTR_W-1:0]] <= bridge_read_data;
      end
   end

   assign busy               = (state_q != S_IDLE);
   assign done               = done_q;
   assign bridge_address     = addr_q;
   assign bridge_read        = (state_q == S_REQ);
   assign bridge_byte_enable = '1;
   assign bridge_write       = 1'b0;
   assign bridge_write_data  = '0;
   assign out_valid          = !fifo_empty;
   assign out_data           = fifo_empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];

endmodule

// File: tb/tb_bridge_burst_reader.sv
// Bench for bridge_burst_reader: a bridge responder, a stream monitor, a directed table,
// hand-written corner sequences and random blocks checked against an arithmetic model.
module tb_bridge_burst_reader;

   localparam int AW = 26;
   localparam int DW = 16;
   localparam int LW = 12;

   logic            clk;
   logic            reset;
   logic            start;
   logic [AW-1:0]   start_addr;
   logic [LW-1:0]   word_count;
   logic            abort;
   logic            busy;
   logic            done;
   logic [AW-1:0]   bridge_address;
   logic [DW/8-1:0] bridge_byte_enable;
   logic            bridge_read;
   logic            bridge_write;
   logic [DW-1:0]   bridge_write_data;
   logic            bridge_acknowledge;
   logic [DW-1:0]   bridge_read_data;
   logic [DW-1:0]   out_data;
   logic            out_valid;
   logic            out_ready;

   bridge_burst_reader #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .FIFO_DEPTH(16)) dut (
      .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
      .word_count(word_count), .abort(abort), .busy(busy), .done(done),
      .bridge_address(bridge_address), .bridge_byte_enable(bridge_byte_enable),
      .bridge_read(bridge_read), .bridge_write(bridge_write),
      .bridge_write_data(bridge_write_data), .bridge_acknowledge(bridge_acknowledge),
      .bridge_read_data(bridge_read_data), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Responder and consumer controls
   int            ack_delay  = 3;
   int            slow_idx   = -1;
   int            rsp_reads  = 0;
   bit            rsp_en     = 1;
   bit            manual_ack = 0;
   int            ready_mode = 0;
   logic [AW-1:0] blk_base   = '0;

   // Monitor state
   logic [AW-1:0] read_q[$];
   logic [DW-1:0] out_q[$];
   int done_cnt, gap_err, stab_err, done_busy_err;
   bit busy_seen;

   typedef struct {
      logic [AW-1:0] addr;
      int            n;
      int            dly;
      int            rmode;
      bit            inject;
      int            exp_reads;
      logic [AW-1:0] exp_first;
      logic [AW-1:0] exp_last;
      logic [DW-1:0] exp_last_data;
   } vec_t;
   vec_t tbl [5];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Bridge responder: acknowledges each read after a programmable number of cycles.
   initial begin
      int wait_cnt;
      int d;
      logic [AW-1:0] diff;
      logic auto_ack;
      wait_cnt = 0;
      bridge_acknowledge = 1'b0;
      bridge_read_data = '0;
      forever begin
         @(posedge clk);
         #1;
         auto_ack = 1'b0;
         if (rsp_en && bridge_read) begin
            wait_cnt++;
            d = (rsp_reads == slow_idx) ? 5 : ack_delay;
            if (wait_cnt >= d) begin
               auto_ack = 1'b1;
               wait_cnt = 0;
               rsp_reads++;
            end
         end else begin
            wait_cnt = 0;
         end
         diff = bridge_address - blk_base;
         bridge_acknowledge = auto_ack || manual_ack;
         bridge_read_data = auto_ack ? (16'hA000 + diff[16:1]) : (manual_ack ? 16'hDEAD : 16'h0000);
      end
   end

   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom % 2);
            default: out_ready = 1'b0;
         endcase
      end
   end

   // Monitor: logs read requests, delivered words and done pulses; flags protocol slips.
   initial begin
      logic prev_read, prev_ack;
      logic [AW-1:0] prev_addr;
      prev_read = 1'b0;
      prev_ack  = 1'b0;
      prev_addr = '0;
      forever begin
         @(negedge clk);
         if (bridge_read) begin
            if (!prev_read || prev_ack) begin
               if (prev_read) gap_err++;
               read_q.push_back(bridge_address);
            end else if (bridge_address !== prev_addr) begin
               stab_err++;
            end
         end
         if (out_valid && out_ready) out_q.push_back(out_data);
         if (done) begin
            done_cnt++;
            if (busy) done_busy_err++;
         end
         if (busy) busy_seen = 1'b1;
         prev_ack  = bridge_read && bridge_acknowledge;
         prev_read = bridge_read;
         prev_addr = bridge_address;
      end
   end

   task automatic clear_mon();
      read_q.delete();
      out_q.delete();
      done_cnt = 0;
      gap_err = 0;
      stab_err = 0;
      done_busy_err = 0;
      busy_seen = 1'b0;
   endtask

   task automatic pulse_start(input logic [AW-1:0] a, input int n);
      @(posedge clk);
      #1;
      start = 1'b1;
      start_addr = a;
      word_count = LW'(n);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int cyc = 0;
      while (done_cnt == 0 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 3000) chk(name, 0, 1);
   endtask

   task automatic drain();
      int cyc = 0;
      ready_mode = 0;
      while (out_valid && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 200) chk("drain_timeout", 0, 1);
      repeat (4) @(negedge clk);
   endtask

   // Reference: a block of n words from base yields reads at base+2i and words A000+i.
   task automatic check_model(input string tag, input logic [AW-1:0] base, input int n);
      int mis_a = 0;
      int mis_d = 0;
      logic [AW-1:0] ea;
      chk({tag, "_n_reads"}, read_q.size(), n);
      chk({tag, "_n_words"}, out_q.size(), n);
      for (int i = 0; i < read_q.size() && i < n; i++) begin
         ea = base + AW'(2 * i);
         if (read_q[i] !== ea) mis_a++;
      end
      for (int i = 0; i < out_q.size() && i < n; i++) begin
         if (out_q[i] !== DW'(16'hA000 + i)) mis_d++;
      end
      chk({tag, "_addr_seq"}, mis_a, 0);
      chk({tag, "_word_order"}, mis_d, 0);
      chk({tag, "_done_pulses"}, done_cnt, 1);
      chk({tag, "_read_gap"}, gap_err, 0);
      chk({tag, "_addr_stable"}, stab_err, 0);
      chk({tag, "_busy_with_done"}, done_busy_err, 0);
      chk({tag, "_busy_seen"}, busy_seen, (n > 0) ? 1 : 0);
   endtask

   task automatic run_block(input string tag, input logic [AW-1:0] a, input int n,
                            input int dly, input int rmode, input bit inject);
      blk_base = a & ~AW'(1);
      ack_delay = dly;
      ready_mode = rmode;
      clear_mon();
      @(posedge clk);
      #1;
      start = 1'b1;
      start_addr = a;
      word_count = LW'(n);
      @(posedge clk);
      #1;
      start = 1'b0;
      if (inject) begin
         start = 1'b1;
         start_addr = 26'h0000555;
         word_count = 12'd7;
      end
      @(negedge clk);
      if (n == 0) begin
         chk({tag, "_zero_done_next"}, done, 1);
         chk({tag, "_zero_busy"}, busy, 0);
      end else begin
         chk({tag, "_busy_n1"}, busy, 1);
         chk({tag, "_read_n1"}, bridge_read, 0);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      if (n > 0) chk({tag, "_read_n2"}, bridge_read, 1);
      wait_done({tag, "_done_timeout"});
      drain();
      check_model(tag, blk_base, n);
   endtask

   initial begin
      int cyc;
      reset = 1'b1;
      start = 1'b0;
      start_addr = '0;
      word_count = '0;
      abort = 1'b0;

      tbl[0] = '{26'h0000100, 4, 3, 0, 1'b0, 4, 26'h0000100, 26'h0000106, 16'hA003};
      tbl[1] = '{26'h3FFFFFE, 2, 2, 0, 1'b0, 2, 26'h3FFFFFE, 26'h0000000, 16'hA001};
      tbl[2] = '{26'h0000200, 0, 1, 0, 1'b0, 0, 26'h0000000, 26'h0000000, 16'h0000};
      tbl[3] = '{26'h0001235, 3, 1, 0, 1'b1, 3, 26'h0001234, 26'h0001238, 16'hA002};
      tbl[4] = '{26'h00ABCDE, 1, 4, 1, 1'b0, 1, 26'h00ABCDE, 26'h00ABCDE, 16'hA000};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_read", bridge_read, 0);
      chk("rst_addr", bridge_address, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_byte_en", bridge_byte_enable, 2'b11);
      chk("rst_write", bridge_write, 0);
      chk("rst_wdata", bridge_write_data, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Directed table
      for (int i = 0; i < 5; i++) begin
         run_block($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].n, tbl[i].dly,
                   tbl[i].rmode, tbl[i].inject);
         chk($sformatf("tbl%0d_reads", i), read_q.size(), tbl[i].exp_reads);
         if (tbl[i].exp_reads > 0 && read_q.size() > 0 && out_q.size() > 0) begin
            chk($sformatf("tbl%0d_first_addr", i), read_q[0], tbl[i].exp_first);
            chk($sformatf("tbl%0d_last_addr", i), read_q[read_q.size()-1], tbl[i].exp_last);
            chk($sformatf("tbl%0d_last_data", i), out_q[out_q.size()-1], tbl[i].exp_last_data);
         end
      end

      // Back-pressure: a full FIFO must stop requests until the consumer drains it
      blk_base = 26'h0002000;
      ack_delay = 2;
      ready_mode = 2;
      clear_mon();
      pulse_start(26'h0002000, 20);
      cyc = 0;
      while (read_q.size() < 16 && cyc < 1000) begin
         @(negedge clk);
         cyc++;
      end
      repeat (40) @(negedge clk);
      chk("bp_reads_held", read_q.size(), 16);
      chk("bp_read_low", bridge_read, 0);
      chk("bp_busy", busy, 1);
      chk("bp_valid", out_valid, 1);
      chk("bp_no_done", done_cnt, 0);
      ready_mode = 0;
      wait_done("bp_done_timeout");
      drain();
      check_model("bp", 26'h0002000, 20);

      // Abort during the third request, whose acknowledge is slow
      blk_base = 26'h0004000;
      ack_delay = 2;
      ready_mode = 2;
      clear_mon();
      slow_idx = rsp_reads + 2;
      pulse_start(26'h0004000, 8);
      cyc = 0;
      while (read_q.size() < 3 && cyc < 500) begin
         @(negedge clk);
         cyc++;
      end
      chk("abort_fifo_filled", out_valid, 1);
      @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      @(negedge clk);
      chk("abort_read_held", bridge_read, 1);
      cyc = 0;
      while (busy && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      chk("abort_busy_fall", busy, 0);
      chk("abort_fifo_flushed", out_valid, 0);
      repeat (20) @(negedge clk);
      chk("abort_reads", read_q.size(), 3);
      if (read_q.size() == 3) chk("abort_third_addr", read_q[2], 26'h0004004);
      chk("abort_no_done", done_cnt, 0);
      chk("abort_addr_stable", stab_err, 0);
      chk("abort_idle_read", bridge_read, 0);
      slow_idx = -1;
      ready_mode = 0;

      // Reset while a request is outstanding; a late acknowledge must be dropped
      blk_base = 26'h0006000;
      ack_delay = 3;
      ready_mode = 2;
      clear_mon();
      pulse_start(26'h0006000, 4);
      cyc = 0;
      while (read_q.size() < 2 && cyc < 500) begin
         @(negedge clk);
         cyc++;
      end
      rsp_en = 1'b0;
      repeat (3) @(negedge clk);
      chk("rreq_read_up", bridge_read, 1);
      chk("rreq_fifo_word", out_valid, 1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rreq_read_dropped", bridge_read, 0);
      chk("rreq_busy", busy, 0);
      chk("rreq_out_valid", out_valid, 0);
      manual_ack = 1'b1;
      @(negedge clk);
      manual_ack = 1'b0;
      repeat (3) @(negedge clk);
      chk("rreq_late_ack_ignored", out_valid, 0);
      rsp_en = 1'b1;
      ready_mode = 0;

      // Random blocks against the arithmetic model
      for (int r = 0; r < 6; r++) begin
         run_block($sformatf("rnd%0d", r), AW'($urandom), int'($urandom_range(24, 1)),
                   int'($urandom_range(4, 1)), 1, 1'($urandom % 2));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bridge_burst_reader.md
Name: bridge_burst_reader

Overview:
- Fabric-side initiator for the SoC's external-bus-to-Avalon bridge (16-bit data, 26-bit byte address, acknowledge handshake).
- Fetches a block of consecutive 16-bit words from SDRAM through the bridge on command and buffers them in an internal FIFO.
- Presents the words to a downstream consumer on a valid/ready stream, e.g. a video line buffer or an audio sample feeder.
- Uses one outstanding bridge transaction at a time and applies back-pressure by throttling requests.

Parameters:
- ADDR_W, 26: bridge byte-address width.
- DATA_W, 16: bridge data width; byte enable is DATA_W/8 bits.
- LEN_W, 12: width of the word-count field; max block is 2^LEN_W-1 words.
- FIFO_DEPTH, 16: FIFO entries, power of two, ≥2.

Ports:
- clk  in  1  sole clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle command strobe; ignored while busy=1.
- start_addr  in  ADDR_W  byte address of the first word; bit0 is ignored and forced to 0.
- word_count  in  LEN_W  number of words to fetch.
- abort  in  1  stop the block after the in-flight transaction completes.
- busy  out  1  block in progress.
- done  out  1  one-cycle pulse when the final word of a non-aborted block is acknowledged.
- bridge_address  out  ADDR_W  drives avalon_bridge_address.
- bridge_byte_enable  out  DATA_W/8  constant all-ones.
- bridge_read  out  1  read request.
- bridge_write  out  1  constant 0.
- bridge_write_data  out  DATA_W  constant 0.
- bridge_acknowledge  in  1  transaction-complete pulse from the bridge.
- bridge_read_data  in  DATA_W  read data; valid only in the cycle bridge_acknowledge=1.
- out_data  out  DATA_W  FIFO head, first-word fall-through.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data when out_valid=1 and out_ready=1.

Behaviour:
- Reset: busy=0, done=0, bridge_read=0, bridge_address=0, out_valid=0, out_data=0, FIFO empty, remaining=0, abort_pending=0, state=IDLE.
- IDLE:
  - start=1 with word_count=0: done=1 on the next cycle, no bus activity, busy stays 0.
  - start=1 with word_count>0: latch address={start_addr[ADDR_W-1:1],0} and remaining=word_count; busy=1 next cycle; go to ISSUE.
- ISSUE:
  - If FIFO occupancy < FIFO_DEPTH: assert bridge_read with the current address; go to REQ.
  - Otherwise wait in ISSUE with bridge_read=0.
- Latency: start in cycle N with a non-full FIFO gives bridge_read=1 in cycle N+2.
- REQ:
  - bridge_read and bridge_address are held stable until bridge_acknowledge=1; there is no timeout.
  - In the acknowledge cycle: write bridge_read_data into the FIFO, add 2 to address (modulo 2^ADDR_W, wraps silently to 0), decrement remaining.
  - bridge_read=0 from the cycle after acknowledge; go to GAP.
  - An acknowledge seen while bridge_read=0 is ignored and the data is not stored.
- GAP:
  - One mandatory idle cycle with bridge_read=0, so back-to-back reads are separated by at least 1 low cycle.
  - Then go to ISSUE if remaining>0 and no abort is pending.
  - If remaining=0 (final word was acknowledged): go to IDLE.
- Abort:
  - Sampled in any busy state and latched in abort_pending.
  - In ISSUE: return to IDLE at once.
  - In REQ: the read completes normally and its data is stored; then IDLE.
  - After abort completion the FIFO is flushed, busy=0, and no done pulse is issued.
  - abort in IDLE has no effect.
- done: pulses in the cycle after the final acknowledge. busy falls in the same cycle. The FIFO may still hold data.
- FIFO:
  - A push (acknowledge) and a pop (out_valid & out_ready) in the same cycle leave occupancy unchanged.
  - A push can never occur when full, because ISSUE gates the request and only one read is outstanding.
  - A pop when empty is a no-op.
  - Words leave in the order they were fetched.
- start while busy: ignored, with no effect on the current block.
- reset while in REQ: bridge_read drops the next cycle, and any acknowledge arriving afterwards is ignored.

Test Plan:
- Basic block: start_addr=0x000100, word_count=4, acknowledge 3 cycles after each read, out_ready=1 → reads at 0x100/0x102/0x104/0x106, each separated by ≥1 low cycle; out_data 0xA000..0xA003 in order; one done pulse; busy falls with done.
- Back-pressure: FIFO_DEPTH=16, word_count=20, out_ready=0 → exactly 16 reads issued, then bridge_read stays 0. Raise out_ready → remaining 4 reads issue; 20 words out in order; done pulses once.
- Zero length: start with word_count=0 → done=1 the next cycle; bridge_read never asserts; busy stays 0.
- Abort mid-transfer: word_count=8, assert abort during the 3rd REQ with acknowledge delayed 5 cycles → bridge_read held until acknowledge; no 4th read; FIFO empty afterwards; no done pulse.
- Address wrap: start_addr=0x3FFFFFE, word_count=2 → reads at 0x3FFFFFE then 0x0000000.
- Reset while waiting for acknowledge: assert reset while bridge_read=1 → the next cycle shows bridge_read=0, busy=0, out_valid=0; a late acknowledge pushes nothing into the FIFO.
